// File: rtl/fetch_pkg.sv
// Shared types for the fetch next-PC sequencer: PC-mux select codes and FSM states.
package fetch_pkg;

    typedef enum logic [1:0] {
        SEL_PC4  = 2'b00,
        SEL_JMP  = 2'b01,
        SEL_DOA  = 2'b10,
        SEL_ZERO = 2'b11
    } sel_dir_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam int FCNT_W = 3;

endpackage

// File: rtl/fetch_if.sv
// Execute-lane resolution inputs and fetch PC-mux controls between the pipeline and fetch_ctrl.
interface fetch_if #(
    parameter int CNT_W = 16
);
    logic             ex_vld1;
    logic             ex_jmp1;
    logic             ex_jr1;
    logic             ex_vld2;
    logic             ex_jmp2;
    logic             ex_jr2;
    logic             restart;
    logic [1:0]       SEL_DIR;
    logic             SEL_JA;
    logic             kill_ex2;
    logic             flush;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] redir_cnt;

    modport master (
        output ex_vld1, ex_jmp1, ex_jr1, ex_vld2, ex_jmp2, ex_jr2, restart,
        input  SEL_DIR, SEL_JA, kill_ex2, flush, busy, err, redir_cnt
    );

    modport slave (
        input  ex_vld1, ex_jmp1, ex_jr1, ex_vld2, ex_jmp2, ex_jr2, restart,
        output SEL_DIR, SEL_JA, kill_ex2, flush, busy, err, redir_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         reloj,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer: picks the fetch PC source from EX jump resolutions and
// squashes wrong-path fetches for FLUSH_CYC cycles after each redirect.
module fetch_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic reloj,
    input  logic reset,
    fetch_if.slave bus
);
    import fetch_pkg::*;

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [FCNT_W-1:0]   fcnt;
    logic [FCNT_W-1:0]   fcnt_nxt;
    logic                err_q;
    logic                err_set;
    logic                redir_inc;
    logic                jmp_l1;
    logic                jmp_l2;
    sel_dir_t            sel_dir;
    logic                sel_ja;
    logic                kill_ex2;
    logic                flush;

    assign jmp_l1 = bus.ex_vld1 & (bus.ex_jmp1 | bus.ex_jr1);
    assign jmp_l2 = bus.ex_vld2 & (bus.ex_jmp2 | bus.ex_jr2);

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
            fcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = ST_BOOT;
        fcnt_nxt  = fcnt;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                state_nxt = ST_RUN;
                if (bus.restart || jmp_l1 || jmp_l2) begin
                    state_nxt = ST_FLUSH;
                    fcnt_nxt  = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                // restart reloads the window; jump flags here belong to squashed instructions
                if (bus.restart) begin
                    state_nxt = ST_FLUSH;
                    fcnt_nxt  = FLUSH_LOAD;
                end else if (fcnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_FLUSH;
                    fcnt_nxt  = fcnt - FCNT_W'(1);
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    assign err_set   = (state == ST_RUN) &&
                       ((bus.ex_vld1 && bus.ex_jmp1 && bus.ex_jr1) ||
                        (bus.ex_vld2 && bus.ex_jmp2 && bus.ex_jr2));
    assign redir_inc = (state == ST_RUN) && !bus.restart && (jmp_l1 || jmp_l2);

    always_comb begin
        sel_dir  = SEL_PC4;
        sel_ja   = 1'b0;
        kill_ex2 = 1'b0;
        flush    = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.restart) begin
                    sel_dir = SEL_ZERO;
                end else if (jmp_l1) begin
                    sel_dir  = bus.ex_jmp1 ? SEL_JMP : SEL_DOA;
                    kill_ex2 = 1'b1;
                end else if (jmp_l2) begin
                    sel_dir = bus.ex_jmp2 ? SEL_JMP : SEL_DOA;
                    sel_ja  = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (bus.restart) begin
                    sel_dir = SEL_ZERO;
                end
            end
            default: begin
                sel_dir = SEL_ZERO;
                flush   = 1'b1;
            end
        endcase
    end

    assign bus.SEL_DIR  = sel_dir;
    assign bus.SEL_JA   = sel_ja;
    assign bus.kill_ex2 = kill_ex2;
    assign bus.flush    = flush;
    assign bus.busy     = (state != ST_RUN);
    assign bus.err      = err_q;

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .reloj (reloj),
        .reset (reset),
        .inc   (redir_inc),
        .cnt   (bus.redir_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random checks of fetch_ctrl against a cycle-level reference model.
module tb_fetch_ctrl;

    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 16;

    logic reloj = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // reference model: boot flag, remaining flush cycles, sticky error, redirect count
    bit   m_boot = 1'b1;
    int   m_left = 0;
    bit   m_err  = 1'b0;
    int   m_cnt  = 0;

    fetch_if #(.CNT_W(CNT_W)) bus ();

    fetch_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rs, input bit v1, input bit j1, input bit r1,
                         input bit v2, input bit j2, input bit r2);
        bus.restart = rs;
        bus.ex_vld1 = v1; bus.ex_jmp1 = j1; bus.ex_jr1 = r1;
        bus.ex_vld2 = v2; bus.ex_jmp2 = j2; bus.ex_jr2 = r2;
    endtask

    task automatic step(input string tag, input bit rs, input bit v1, input bit j1, input bit r1,
                        input bit v2, input bit j2, input bit r2);
        int  e_sel;
        bit  e_ja, e_kill, e_flush, e_busy;
        bit  l1, l2;
        @(negedge reloj);
        reset = 1'b1;
        drive(rs, v1, j1, r1, v2, j2, r2);
        #1;
        e_sel = 0; e_ja = 0; e_kill = 0; e_flush = 0; e_busy = 1;
        chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
        chk({tag, ".cnt"}, 32'(bus.redir_cnt), 32'(m_cnt));
        if (m_boot) begin
            e_sel   = 3;
            e_flush = 1;
            m_boot  = 1'b0;
        end else if (m_left > 0) begin
            e_flush = 1;
            if (rs) begin
                e_sel  = 3;
                m_left = FLUSH_CYC;
            end else begin
                m_left = m_left - 1;
            end
        end else begin
            e_busy = 0;
            l1 = v1 && (j1 || r1);
            l2 = v2 && (j2 || r2);
            if ((v1 && j1 && r1) || (v2 && j2 && r2)) m_err = 1'b1;
            if (rs) begin
                e_sel  = 3;
                m_left = FLUSH_CYC;
            end else if (l1) begin
                e_sel  = j1 ? 1 : 2;
                e_kill = 1;
                m_left = FLUSH_CYC;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end else if (l2) begin
                e_sel  = j2 ? 1 : 2;
                e_ja   = 1;
                m_left = FLUSH_CYC;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
        chk({tag, ".sel_dir"}, 32'(bus.SEL_DIR), 32'(e_sel));
        chk({tag, ".sel_ja"}, 32'(bus.SEL_JA), 32'(e_ja));
        chk({tag, ".kill_ex2"}, 32'(bus.kill_ex2), 32'(e_kill));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(e_flush));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".sel_dir"}, 32'(bus.SEL_DIR), 32'd3);
        chk({tag, ".sel_ja"}, 32'(bus.SEL_JA), 32'd0);
        chk({tag, ".kill_ex2"}, 32'(bus.kill_ex2), 32'd0);
        chk({tag, ".flush"}, 32'(bus.flush), 32'd1);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".err"}, 32'(bus.err), 32'd0);
        chk({tag, ".cnt"}, 32'(bus.redir_cnt), 32'd0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #23;
        check_reset_outputs("in_reset");

        // boot then sequential fetch
        idle("boot", 1);
        idle("seq", 3);

        // lane-1 J jump, kills lane 2, flush window
        step("l1_jmp", 0, 1, 1, 0, 0, 0, 0);
        idle("l1_flush", FLUSH_CYC);
        idle("l1_back", 1);

        // both lanes JR: lane 1 wins
        step("both_jr", 0, 1, 0, 1, 1, 0, 1);
        idle("both_flush", FLUSH_CYC + 1);

        // lane-2 JR, then jump flag during flush ignored
        step("l2_jr", 0, 0, 0, 0, 1, 0, 1);
        step("flush_ign", 0, 1, 1, 0, 0, 0, 0);
        idle("l2_back", 2);

        // restart on 2nd flush cycle extends the window
        step("rs_jmp", 0, 1, 1, 0, 0, 0, 0);
        idle("rs_f1", 1);
        step("rs_f2", 1, 0, 0, 0, 0, 0, 0);
        idle("rs_ext", FLUSH_CYC + 1);

        // restart from RUN does not count as a redirect
        step("rs_run", 1, 0, 0, 0, 0, 0, 0);
        idle("rs_run_fl", FLUSH_CYC + 1);

        // jmp+jr conflict sets sticky err, then async reset mid-flush
        step("conflict", 0, 1, 1, 1, 0, 0, 0);
        idle("conf_f1", 1);
        @(negedge reloj);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_boot = 1'b1; m_left = 0; m_err = 1'b0; m_cnt = 0;
        @(posedge reloj);
        idle("reboot", 2);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) == 0),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
